// File: rtl/fir_sched_pkg.sv
// fir_sched_pkg: shared FSM encoding, defaults and width helpers for the FIR channel scheduler.
package fir_sched_pkg;
    localparam int DEFAULT_TAPS = 256;
    localparam int DEFAULT_NUM_CH = 4;
    typedef enum logic [1:0] {IDLE, START, RUN, WAIT_DONE} state_t;
    function automatic int addr_w(input int taps);
        return taps > 1 ? $clog2(taps) : 1;
    endfunction
    function automatic int bank_w(input int num_ch);
        return num_ch > 1 ? $clog2(num_ch) : 1;
    endfunction
endpackage

// File: rtl/fir_channel_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin search starting after the last granted channel.
module rr_arbiter
    import fir_sched_pkg::*;
#(
    parameter int NUM_CH = DEFAULT_NUM_CH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         req,
    input  logic                      advance,
    output logic [bank_w(NUM_CH)-1:0] grant_idx,
    output logic                      any_req
);
    localparam int BW = bank_w(NUM_CH);
    logic [BW-1:0] ptr;
    // Walk offsets from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        grant_idx = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            logic [BW-1:0] j;
            j = BW'((int'(ptr) + i) % NUM_CH);
            if (req[j]) grant_idx = j;
        end
    end
    assign any_req = |req;
    always_ff @(posedge clock or posedge reset)
        if (reset) ptr <= BW'(NUM_CH - 1);
        else if (advance && any_req) ptr <= grant_idx;
endmodule

// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler: time-shares one FIR engine between NUM_CH channels,
// buffering one sample per channel and routing tagged results back.
module fir_channel_scheduler
    import fir_sched_pkg::*;
#(
    parameter int NUM_CH      = DEFAULT_NUM_CH,
    parameter int DATA_W      = 24,
    parameter int OUT_WIDTH   = 32,
    parameter int TAPS        = DEFAULT_TAPS,
    parameter int COEFF_DELAY = 2,
    parameter int TIMEOUT     = 272
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          ch_strobe,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic                       eng_start,
    output logic [DATA_W-1:0]          eng_data,
    output logic [addr_w(TAPS)-1:0]    coeff_addr,
    output logic [bank_w(NUM_CH)-1:0]  coeff_bank,
    input  logic                       eng_strobe,
    input  logic [OUT_WIDTH-1:0]       eng_result,
    input  logic                       eng_done,
    output logic                       out_strobe,
    output logic [OUT_WIDTH-1:0]       out_data,
    output logic [bank_w(NUM_CH)-1:0]  out_channel,
    output logic                       busy,
    output logic [NUM_CH-1:0]          overrun,
    input  logic                       clear_overrun,
    output logic                       timeout_err
);
    localparam int AW = addr_w(TAPS);
    localparam int BW = bank_w(NUM_CH);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] pending, consume, ovr_evt;
    logic [DATA_W-1:0] slot [NUM_CH];
    logic [BW-1:0]     grant, arb_idx;
    logic              any_req, active, tmo;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     addr;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (pending),
        .advance   (state == IDLE),
        .grant_idx (arb_idx),
        .any_req   (any_req)
    );

    assign active      = state == RUN || state == WAIT_DONE;
    assign tmo         = active && !eng_done && cnt == CW'(TIMEOUT - 1);
    assign consume     = (state == START) ? (NUM_CH'(1) << grant) : '0;
    assign ovr_evt     = ch_strobe & pending & ~consume;
    assign eng_start   = state == START;
    assign busy        = state != IDLE;
    assign eng_data    = eng_start ? slot[grant] : '0;
    assign coeff_addr  = addr;
    assign coeff_bank  = grant;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = any_req ? START : IDLE;
            START:     state_nxt = RUN;
            RUN:       state_nxt = (eng_done || tmo) ? IDLE : (addr == AW'(TAPS - 1)) ? WAIT_DONE : RUN;
            WAIT_DONE: state_nxt = (eng_done || tmo) ? IDLE : WAIT_DONE;
            default:   state_nxt = IDLE;
        endcase
    end

    // cnt measures cycles since eng_start; it also paces the coefficient address.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            cnt   <= '0;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) grant <= arb_idx;
            cnt  <= (state == IDLE) ? '0 : cnt + CW'(1);
            addr <= !active ? '0
                  : (state == RUN && cnt >= CW'(COEFF_DELAY) && addr != AW'(TAPS - 1)) ? addr + AW'(1)
                  : addr;
        end

    // A fresh overrun or timeout in the clearing cycle keeps its flag set.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            pending     <= '0;
            overrun     <= '0;
            timeout_err <= 1'b0;
        end else begin
            pending     <= ch_strobe | (pending & ~consume);
            overrun     <= (clear_overrun ? '0 : overrun) | ovr_evt;
            timeout_err <= (timeout_err && !clear_overrun) || tmo;
        end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        always_ff @(posedge clock or posedge reset)
            if (reset) slot[k] <= '0;
            else if (ch_strobe[k]) slot[k] <= ch_data[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            out_strobe  <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
        end else begin
            out_strobe <= eng_strobe && active;
            if (eng_strobe && active) begin
                out_data    <= eng_result;
                out_channel <= grant;
            end
        end
endmodule
